// File: rtl/shell_init_sequencer.sv
// Shell bring-up sequencer: holds NUM_CH subsystems in reset, then releases them in index order.
// Define SHELL_SEQ_RETRY_EN to re-release a timed-out channel up to MAX_RETRY times before failing.
module shell_init_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRY      = 3
) (
  input  logic                                           CLK,
  input  logic                                           rstn,
  input  logic [NUM_CH-1:0]                              ch_ready_i,
  output logic [NUM_CH-1:0]                              ch_rstn_o,
  output logic                                           all_ready_o,
  output logic                                           timeout_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch_o,
  output logic [7:0]                                     restart_cnt_o
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CH    = CW'(NUM_CH - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  // IDLE -> HOLD (all held) -> WAIT(idx) per channel -> DONE; FAIL is sticky until rstn
`ifdef SHELL_SEQ_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);
  localparam logic [HW-1:0] RHOLD_LAST  = HW'(HOLD_CYCLES - 1);
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_WAIT, S_DONE, S_FAIL, S_RETRY_HOLD} state_t;
  logic [RW-1:0] retry_q, retry_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_WAIT, S_DONE, S_FAIL} state_t;
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_CH-1:0]   chr_q, chr_d;
  logic                all_q, all_d;
  logic                to_q, to_d;
  logic [CW-1:0]       fail_q, fail_d;
  logic [7:0]          rcnt_q, rcnt_d;
  logic [NUM_CH-1:0]   lower_mask;
  logic                lower_loss;
  logic                restart;
  logic                time_out;
  logic                go_fail;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    timer_d    = timer_q;
    chr_d      = chr_q;
    all_d      = all_q;
    to_d       = to_q;
    fail_d     = fail_q;
    rcnt_d     = rcnt_q;
    restart    = 1'b0;
    time_out   = 1'b0;
    go_fail    = 1'b0;
`ifdef SHELL_SEQ_RETRY_EN
    retry_d    = retry_q;
`endif
    lower_mask = (NUM_CH'(1) << idx_q) - NUM_CH'(1);
    lower_loss = |(~ch_ready_i & lower_mask);

    case (state_q)
      S_IDLE: begin
        state_d = S_HOLD;
        hold_d  = '0;
        chr_d   = '0;
      end
      S_HOLD: begin
        chr_d = '0;
        if (hold_q == HOLD_LAST) begin
          state_d = S_WAIT;
          idx_d   = '0;
          chr_d   = NUM_CH'(1);
          timer_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_WAIT: begin
        // loss of an already-ready channel outranks the current channel's ready/timeout
        if (lower_loss) begin
          restart = 1'b1;
        end else if (ch_ready_i[idx_q]) begin
`ifdef SHELL_SEQ_RETRY_EN
          retry_d = '0;
`endif
          if (idx_q == LAST_CH) begin
            state_d = S_DONE;
            all_d   = 1'b1;
          end else begin
            idx_d                 = idx_q + 1'b1;
            chr_d[idx_q + 1'b1]   = 1'b1;
            timer_d               = '0;
          end
        end else if (timer_q == TIMER_LAST) begin
          time_out = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!(&ch_ready_i)) restart = 1'b1;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
`ifdef SHELL_SEQ_RETRY_EN
      S_RETRY_HOLD: begin
        if (lower_loss) begin
          restart = 1'b1;
        end else if (hold_q == RHOLD_LAST) begin
          state_d      = S_WAIT;
          chr_d[idx_q] = 1'b1;
          timer_d      = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (time_out) begin
`ifdef SHELL_SEQ_RETRY_EN
      if (retry_q == RETRY_MAX) begin
        go_fail = 1'b1;
      end else begin
        retry_d      = retry_q + 1'b1;
        state_d      = S_RETRY_HOLD;
        hold_d       = '0;
        chr_d[idx_q] = 1'b0;
      end
`else
      go_fail = 1'b1;
`endif
    end

    if (go_fail) begin
      state_d = S_FAIL;
      to_d    = 1'b1;
      fail_d  = idx_q;
      chr_d   = '0;
      all_d   = 1'b0;
    end

    if (restart) begin
      state_d = S_HOLD;
      hold_d  = '0;
      chr_d   = '0;
      all_d   = 1'b0;
      if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
`ifdef SHELL_SEQ_RETRY_EN
      retry_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      timer_q <= '0;
      chr_q   <= '0;
      all_q   <= 1'b0;
      to_q    <= 1'b0;
      fail_q  <= '0;
      rcnt_q  <= '0;
`ifdef SHELL_SEQ_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      chr_q   <= chr_d;
      all_q   <= all_d;
      to_q    <= to_d;
      fail_q  <= fail_d;
      rcnt_q  <= rcnt_d;
`ifdef SHELL_SEQ_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign ch_rstn_o     = chr_q;
  assign all_ready_o   = all_q;
  assign timeout_o     = to_q;
  assign fail_ch_o     = fail_q;
  assign restart_cnt_o = rcnt_q;

endmodule

// File: tb/tb_shell_init_sequencer.sv
// Randomized bench for shell_init_sequencer: emulated subsystems drive ready, and a
// timestamp-based reference model predicts every output each cycle.
`timescale 1ns/1ps
module tb_shell_init_sequencer;
  localparam int NCH  = 3;
  localparam int HOLD = 4;
  localparam int TMO  = 32;
  localparam int MAXR = 3;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [NCH-1:0] ch_ready = '0;
  logic [NCH-1:0] ch_rstn;
  logic           all_ready;
  logic           timeout;
  logic [1:0]     fail_ch;
  logic [7:0]     restart_cnt;

  always #5 clk = ~clk;

  shell_init_sequencer #(
    .NUM_CH(NCH), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .CLK(clk), .rstn(rstn), .ch_ready_i(ch_ready), .ch_rstn_o(ch_rstn),
    .all_ready_o(all_ready), .timeout_o(timeout), .fail_ch_o(fail_ch),
    .restart_cnt_o(restart_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // reference model: edge timestamps rather than counters
  bit m_run, m_done, m_failed, m_dropped;
  int m_seq_t, m_rel, m_rel_t, m_drop_t, m_fail_ch, m_restarts, m_retries;

  function automatic void model_edge();
    int  guarded;
    bit  loss;
    cyc++;
    if (!rstn) begin
      m_run = 0; m_rel = 0; m_done = 0; m_failed = 0; m_dropped = 0;
      m_fail_ch = 0; m_restarts = 0; m_retries = 0;
      return;
    end
    if (!m_run) begin
      m_run = 1; m_seq_t = cyc; m_rel = 0;
      return;
    end
    if (m_failed) return;
    loss = 0;
    if (m_rel > 0) begin
      guarded = m_done ? NCH : m_rel - 1;
      for (int j = 0; j < guarded; j++) if (!ch_ready[j]) loss = 1;
    end
    if (loss) begin
      m_rel = 0; m_done = 0; m_dropped = 0; m_retries = 0; m_seq_t = cyc;
      if (m_restarts < 255) m_restarts++;
      return;
    end
    if (m_rel == 0) begin
      if (cyc == m_seq_t + HOLD + 1) begin m_rel = 1; m_rel_t = cyc; end
      return;
    end
    if (m_done) return;
    if (m_dropped) begin
      if (cyc == m_drop_t + HOLD) begin m_dropped = 0; m_rel_t = cyc; end
      return;
    end
    if (ch_ready[m_rel-1]) begin
      m_retries = 0;
      if (m_rel == NCH) m_done = 1;
      else begin m_rel++; m_rel_t = cyc; end
      return;
    end
    if (cyc == m_rel_t + TMO) begin
`ifdef SHELL_SEQ_RETRY_EN
      if (m_retries < MAXR) begin
        m_retries++; m_dropped = 1; m_drop_t = cyc;
        return;
      end
`endif
      m_failed = 1; m_fail_ch = m_rel - 1;
    end
  endfunction

  task automatic check_outputs();
    int exp_rstn;
    exp_rstn = 0;
    if (m_run && !m_failed && m_rel > 0) begin
      exp_rstn = (1 << m_rel) - 1;
      if (m_dropped) exp_rstn = exp_rstn & ~(1 << (m_rel - 1));
    end
    chk("ch_rstn",     32'(ch_rstn),     32'(exp_rstn));
    chk("all_ready",   32'(all_ready),   32'(m_done));
    chk("timeout",     32'(timeout),     32'(m_failed));
    chk("fail_ch",     32'(fail_ch),     32'(m_fail_ch));
    chk("restart_cnt", 32'(restart_cnt), 32'(m_restarts));
  endtask

  // emulated subsystems: ready rises dly cycles after release; unreleased ready is junk
  int             dly[NCH];
  int             up[NCH];
  int             junk_mode = 0;
  int             glitch_pct = 0;
  int             rst_pct = 0;
  logic [NCH-1:0] kill = '0;

  task automatic drive_next();
    logic [NCH-1:0] nr;
    for (int j = 0; j < NCH; j++) begin
      if (ch_rstn[j]) begin
        up[j]++;
        nr[j] = (up[j] > dly[j]);
      end else begin
        up[j] = 0;
        nr[j] = (junk_mode == 0) ? 1'b0 : (junk_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    if (glitch_pct > 0 && $urandom_range(0, 99) < glitch_pct) nr[$urandom_range(0, NCH-1)] = 1'b0;
    nr       = nr & ~kill;
    kill     = '0;
    ch_ready = nr;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    drive_next();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rstn = (rst_pct > 0 && $urandom_range(0, 99) < rst_pct) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic reset_cycles(input int n);
    rstn = 1'b0;
    for (int i = 0; i < n; i++) step();
    rstn = 1'b1;
  endtask

  initial begin
    for (int j = 0; j < NCH; j++) begin dly[j] = 0; up[j] = 0; end
    reset_cycles(3);

    // ready tied high, including unreleased channels
    junk_mode = 1;
    run(20);
    chk("tied_all_ready", 32'(all_ready), 32'd1);

    // ch1 slow but inside the timeout window
    junk_mode = 0;
    reset_cycles(2);
    dly = '{0, 10, 0};
    run(60);
    chk("slow_ch1_done", 32'(all_ready), 32'd1);
    chk("slow_ch1_no_tmo", 32'(timeout), 32'd0);

    // ch2 never ready
    reset_cycles(2);
    dly = '{0, 0, 1000};
    run(200);
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_ch", 32'(fail_ch), 32'd2);
    chk("tmo_held", 32'(ch_rstn), 32'd0);

    // one-cycle loss in DONE, then rstn during WAIT(1)
    reset_cycles(2);
    dly = '{0, 0, 0};
    run(20);
    kill = 3'b001;
    run(30);
    chk("loss_restart", 32'(restart_cnt), 32'd1);
    chk("loss_rerun", 32'(all_ready), 32'd1);
    dly[1] = 1000;
    kill = 3'b010;
    run(10);
    rstn = 1'b0;
    step();
    chk("mid_rst_cnt", 32'(restart_cnt), 32'd0);
    chk("mid_rst_rstn", 32'(ch_rstn), 32'd0);
    rstn = 1'b1;

    // randomized scenarios, including the ready-on-last-cycle boundary
    for (int s = 0; s < 40; s++) begin
      for (int j = 0; j < NCH; j++) begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3, 4: dly[j] = $urandom_range(0, 6);
          5:             dly[j] = $urandom_range(7, 20);
          6:             dly[j] = TMO - 2 + $urandom_range(0, 3);
          default:       dly[j] = 1000;
        endcase
      end
      junk_mode  = $urandom_range(0, 2);
      glitch_pct = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
      rst_pct    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      reset_cycles($urandom_range(1, 3));
      run($urandom_range(100, 250));
    end

    // heavy loss traffic to push the restart counter into saturation
    rst_pct    = 0;
    junk_mode  = 2;
    glitch_pct = 30;
    dly        = '{0, 0, 0};
    reset_cycles(2);
    run(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
